// File: rtl/ocp_pkg.sv
// rtl/ocp_pkg.sv - shared types for the OCP bridge / memory arbiter slice
package ocp_pkg;

    // Direction of a memory transfer as presented on the shared memory port.
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_access_e;

    // Memory arbiter sequencing: pick a requester, run its access, report.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin find-first
//
// Purpose: find the first set bit of req_vec, starting at start_idx and
// searching upward, wrapping past NUM_REQ-1 back to 0.
//
// Ports:
//   req_vec    in  NUM_REQ  candidate request bits
//   start_idx  in  IDX_W    index with highest priority this cycle
//   valid      out 1        at least one bit of req_vec is set
//   index      out IDX_W    index of the winning bit (0 when !valid)
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   start_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int pos;

    // Walk every offset from start_idx; the first hit wins and later hits
    // are masked by valid, so the loop unrolls into a fixed priority chain.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(start_idx) + i) % NUM_REQ;
            if (!valid && req_vec[IDX_W'(pos)]) begin
                valid = 1'b1;
                index = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory master port
//
// Purpose: grants one of NUM_REQ bridge-style requesters at a time, drives the
// shared memory port for the grantee and returns a one-cycle completion with
// read data. A watchdog ends transfers the memory never completes, flagging
// req_error.
//
// Ports:
//   clk                  in   1                    rising-edge clock
//   reset                in   1                    async active-low reset
//   req_request          in   NUM_REQ              per-requester request level
//   req_type             in   NUM_REQ              0 = read, 1 = write
//   req_address          in   NUM_REQ*ADDR_WIDTH   per-requester address
//   req_write_data       in   NUM_REQ*DATA_WIDTH   per-requester write data
//   req_complete         out  NUM_REQ              one-hot completion pulse
//   req_error            out  1                    transfer timed out
//   req_read_data        out  DATA_WIDTH           read data with req_complete
//   mem_access_request   out  1                    memory request level
//   mem_access_type      out  1                    0 = read, 1 = write
//   mem_address          out  ADDR_WIDTH           memory address
//   mem_write_data       out  DATA_WIDTH           memory write data
//   mem_read_data        in   DATA_WIDTH           valid with access_complete
//   mem_access_complete  in   1                    one-cycle memory completion
//   busy                 out  1                    arbiter not idle
//   grant_id             out  clog2(NUM_REQ)       current / last grantee
module mem_rr_arbiter
    import ocp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_request,
    input  logic [NUM_REQ-1:0]            req_type,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            req_complete,
    output logic                          req_error,
    output logic [DATA_WIDTH-1:0]         req_read_data,
    output logic                          mem_access_request,
    output logic                          mem_access_type,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    input  logic                          mem_access_complete,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e             state;
    logic [GW-1:0]          last_grant;
    logic [CW-1:0]          tmo_cnt;

    logic [GW-1:0]          start_idx;
    logic                   pick_valid;
    logic [GW-1:0]          pick_idx;
    mem_access_e            sel_type;
    logic [ADDR_WIDTH-1:0]  sel_address;
    logic [DATA_WIDTH-1:0]  sel_write_data;

    // The previous grantee is searched last, so it cannot win twice in a row
    // while anybody else is waiting.
    assign start_idx = (last_grant == GW'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GW)
    ) u_picker (
        .req_vec   (req_request),
        .start_idx (start_idx),
        .valid     (pick_valid),
        .index     (pick_idx)
    );

    assign sel_type       = mem_access_e'(req_type[pick_idx]);
    assign sel_address    = req_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_write_data = req_write_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ARB_IDLE;
            last_grant         <= GW'(NUM_REQ - 1);
            tmo_cnt            <= '0;
            grant_id           <= '0;
            req_complete       <= '0;
            req_error          <= 1'b0;
            req_read_data      <= '0;
            mem_access_request <= 1'b0;
            mem_access_type    <= 1'b0;
            mem_address        <= '0;
            mem_write_data     <= '0;
            busy               <= 1'b0;
        end else begin
            // Completion and error only ever live for the single RESP cycle.
            req_complete <= '0;
            req_error    <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        mem_access_type    <= sel_type;
                        mem_address        <= sel_address;
                        mem_write_data     <= sel_write_data;
                        mem_access_request <= 1'b1;
                        last_grant         <= pick_idx;
                        grant_id           <= pick_idx;
                        tmo_cnt            <= '0;
                        busy               <= 1'b1;
                        state              <= ARB_ACCESS;
                    end
                end

                ARB_ACCESS: begin
                    // A completion arriving in the last allowed cycle still
                    // wins over the watchdog.
                    if (mem_access_complete) begin
                        req_read_data      <= mem_read_data;
                        req_complete       <= NUM_REQ'(1) << grant_id;
                        mem_access_request <= 1'b0;
                        state              <= ARB_RESP;
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        req_read_data      <= '0;
                        req_complete       <= NUM_REQ'(1) << grant_id;
                        req_error          <= 1'b1;
                        mem_access_request <= 1'b0;
                        state              <= ARB_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ARB_RESP: begin
                    req_read_data <= '0;
                    busy          <= 1'b0;
                    state         <= ARB_IDLE;
                end

                default: begin
                    mem_access_request <= 1'b0;
                    busy               <= 1'b0;
                    state              <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - self-checking bench for mem_rr_arbiter
module tb_mem_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_request;
    logic [NR-1:0]    req_type;
    logic [NR*AW-1:0] req_address;
    logic [NR*DW-1:0] req_write_data;
    logic [NR-1:0]    req_complete;
    logic             req_error;
    logic [DW-1:0]    req_read_data;
    logic             mem_access_request;
    logic             mem_access_type;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_write_data;
    logic [DW-1:0]    mem_read_data;
    logic             mem_access_complete;
    logic             busy;
    logic [1:0]       grant_id;

    int n_assert = 0;
    int n_fail   = 0;

    // Requester-side view kept by the bench; drives the packed DUT inputs.
    logic          r_req   [NR];
    logic          r_type  [NR];
    logic [AW-1:0] r_addr  [NR];
    logic [DW-1:0] r_wdata [NR];
    int            model_last;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_request         (req_request),
        .req_type            (req_type),
        .req_address         (req_address),
        .req_write_data      (req_write_data),
        .req_complete        (req_complete),
        .req_error           (req_error),
        .req_read_data       (req_read_data),
        .mem_access_request  (mem_access_request),
        .mem_access_type     (mem_access_type),
        .mem_address         (mem_address),
        .mem_write_data      (mem_write_data),
        .mem_read_data       (mem_read_data),
        .mem_access_complete (mem_access_complete),
        .busy                (busy),
        .grant_id            (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_request[i]              = r_req[i];
            req_type[i]                 = r_type[i];
            req_address[i*AW +: AW]     = r_addr[i];
            req_write_data[i*DW +: DW]  = r_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[i]   = 1'b1;
        r_type[i]  = t;
        r_addr[i]  = a;
        r_wdata[i] = d;
    endtask

    // Round-robin reference: scan upward from the slot after the last
    // grantee, wrapping, and take the first requester that is asking.
    function automatic int model_pick();
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (model_last + k) % NR;
            if (r_req[c]) return c;
        end
        return -1;
    endfunction

    // Waits for the grant, checks the memory port, then completes after lat
    // ACCESS cycles (lat < 0: never complete, expect the watchdog).
    // Returns while req_complete is high.
    task automatic transfer(input int id, input int lat, input logic [DW-1:0] rdata);
        int k;
        k = 0;
        while (mem_access_request !== 1'b1 && k < 16) begin
            tick();
            k++;
        end
        chk("grant_seen", mem_access_request, 1);
        chk("grant_id", grant_id, id);
        chk("mem_address", mem_address, r_addr[id]);
        chk("mem_type", mem_access_type, r_type[id]);
        chk("mem_wdata", mem_write_data, r_wdata[id]);
        chk("busy_access", busy, 1);
        if (lat >= 0) begin
            for (int c = 0; c < lat; c++) begin
                tick();
                chk("hold_req", {req_complete, mem_access_request}, 5'b00001);
            end
            mem_access_complete = 1'b1;
            mem_read_data       = rdata;
            tick();
            mem_access_complete = 1'b0;
            mem_read_data       = 32'hA5A5_0F0F;
            chk("complete", req_complete, 4'b0001 << id);
            chk("read_data", req_read_data, rdata);
            chk("error_clear", req_error, 0);
        end else begin
            mem_read_data = 32'hFFFF_FFFF;
            for (int c = 0; c < TO - 1; c++) begin
                tick();
                chk("to_wait", {req_complete, mem_access_request}, 5'b00001);
            end
            tick();
            chk("to_complete", req_complete, 4'b0001 << id);
            chk("to_error", req_error, 1);
            chk("to_read_zero", req_read_data, 0);
        end
        chk("req_drop", mem_access_request, 0);
        chk("busy_resp", busy, 1);
        model_last = id;
    endtask

    task automatic finish_resp();
        tick();
        chk("pulse_one", req_complete, 0);
        chk("err_one", req_error, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int            exp_id;
        int            lat;
        int            any;
        int            order [5];

        reset               = 1'b0;
        mem_read_data       = '0;
        mem_access_complete = 1'b0;
        for (int i = 0; i < NR; i++) begin
            r_req[i] = 1'b0; r_type[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        model_last = NR - 1;
        drive();

        // Reset values
        repeat (3) tick();
        chk("rst_outputs", {req_complete, req_error, mem_access_request, mem_access_type, busy, grant_id}, 0);
        chk("rst_addr_wdata", {mem_address, mem_write_data, req_read_data}, 0);
        reset = 1'b1;
        tick();
        chk("idle_no_req", {mem_access_request, busy}, 0);

        // Contention: all four write and hold, expect 0,1,2,3,0
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b1, AW'(i + 4), 32'hC0DE_0000 + DW'(i * 17));
        drive();
        order = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            rd = $urandom();
            transfer(order[n], n % 3, rd);
            if (n == 4) begin
                for (int i = 0; i < NR; i++) r_req[i] = 1'b0;
                drive();
            end
            finish_resp();
        end

        // Single read by requester 2, memory completes 3 cycles later
        set_req(2, 1'b0, 5'h0A, 32'h1234_5678);
        drive();
        tick();
        chk("grant_latency", mem_access_request, 1);
        transfer(2, 3, 32'hDEADBEEF);
        r_req[2] = 1'b0;
        drive();
        finish_resp();

        // Fairness: 1 reissues at once, 3 waiting -> 1,3,1,3
        set_req(1, 1'b1, 5'h11, 32'h0000_1111);
        drive();
        transfer(1, 0, 32'h1);
        set_req(1, 1'b1, 5'h12, 32'h0000_1112);
        set_req(3, 1'b0, 5'h13, 32'h0000_3333);
        drive();
        finish_resp();
        transfer(3, 1, 32'h3);
        set_req(3, 1'b1, 5'h14, 32'h0000_3334);
        drive();
        finish_resp();
        transfer(1, 0, 32'h11);
        set_req(1, 1'b0, 5'h15, 32'h0000_1113);
        drive();
        finish_resp();
        transfer(3, 2, 32'h33);
        r_req[1] = 1'b0; r_req[3] = 1'b0;
        drive();
        finish_resp();

        // Timeout on requester 0, then requester 2 served normally
        set_req(0, 1'b0, 5'h1F, 32'h0);
        drive();
        transfer(0, -1, 32'h0);
        r_req[0] = 1'b0;
        set_req(2, 1'b1, 5'h02, 32'hBEEF_0002);
        drive();
        finish_resp();
        transfer(2, 1, 32'h2222_2222);
        r_req[2] = 1'b0;
        drive();
        finish_resp();

        // Stray complete in IDLE
        mem_access_complete = 1'b1;
        mem_read_data       = 32'h7777_7777;
        tick();
        mem_access_complete = 1'b0;
        chk("stray_no_complete", {req_complete, req_error, mem_access_request, busy}, 0);
        tick();
        chk("stray_still_idle", {req_complete, mem_access_request, busy}, 0);
        set_req(1, 1'b0, 5'h09, 32'h0);
        drive();
        transfer(1, 0, 32'h0909_0909);
        r_req[1] = 1'b0;
        drive();
        finish_resp();

        // Reset asserted mid-ACCESS
        set_req(3, 1'b1, 5'h1C, 32'hFACE_0003);
        drive();
        tick();
        chk("pre_reset_access", mem_access_request, 1);
        tick();
        #3 reset = 1'b0;
        #1;
        chk("arst_ctrl", {req_complete, req_error, mem_access_request, mem_access_type, busy, grant_id}, 0);
        chk("arst_data", {mem_address, mem_write_data, req_read_data}, 0);
        for (int i = 0; i < NR; i++) r_req[i] = 1'b0;
        drive();
        model_last = NR - 1;
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_quiet", {req_complete, mem_access_request, busy}, 0);
        set_req(0, 1'b0, 5'h01, 32'h0);
        set_req(2, 1'b1, 5'h03, 32'h0303_0303);
        drive();
        transfer(0, 1, 32'hAAAA_0000);
        r_req[0] = 1'b0;
        drive();
        finish_resp();
        transfer(2, 0, 32'h5555_2222);
        r_req[2] = 1'b0;
        drive();
        finish_resp();

        // Randomized traffic against the round-robin reference
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++)
                if (!r_req[i] && $urandom_range(0, 99) < 40)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom()), $urandom());
            any = 0;
            for (int i = 0; i < NR; i++) if (r_req[i]) any = 1;
            if (any == 0)
                set_req(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)), AW'($urandom()), $urandom());
            drive();
            exp_id = model_pick();
            lat    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            rd     = $urandom();
            transfer(exp_id, lat, rd);
            if ($urandom_range(0, 1) == 1)
                set_req(exp_id, 1'($urandom_range(0, 1)), AW'($urandom()), $urandom());
            else
                r_req[exp_id] = 1'b0;
            drive();
            finish_resp();
        end

        for (int i = 0; i < NR; i++) r_req[i] = 1'b0;
        drive();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
